// File: rtl/lc3_execute_stage.sv
// LC3 Execute stage: operand forwarding, ALU, address generation and the
// Execute -> Memory/Writeback pipeline register.
// Optional feature macro: LC3_EXEC_VALID_EN adds the exec_valid output, a flag
// that marks cycles in which the registered outputs were freshly loaded.
module lc3_execute_stage #(
   parameter int         DATA_W    = 16,      // LC3 word width; only 16 is supported
   parameter logic [2:0] RESET_NZP = 3'b000
) (
   input  logic              clock,
   input  logic              reset,           // async, active low
   input  logic              enable_execute,
   input  logic [15:0]       IR,
   input  logic [DATA_W-1:0] npc_in,
   input  logic [5:0]        E_control,
   input  logic [1:0]        W_control_in,
   input  logic              Mem_control_in,
   input  logic [DATA_W-1:0] Mem_bypass_val,
   input  logic [DATA_W-1:0] VSR1,
   input  logic [DATA_W-1:0] VSR2,
   input  logic              bypass_alu_1,
   input  logic              bypass_alu_2,
   input  logic              bypass_mem_1,
   input  logic              bypass_mem_2,
`ifdef LC3_EXEC_VALID_EN
   output logic              exec_valid,
`endif
   output logic [DATA_W-1:0] aluout,
   output logic [DATA_W-1:0] pcout,
   output logic [2:0]        dr,
   output logic [2:0]        sr1,
   output logic [2:0]        sr2,
   output logic [15:0]       IR_Exec,
   output logic [2:0]        NZP,
   output logic [1:0]        W_control_out,
   output logic              Mem_control_out,
   output logic [DATA_W-1:0] M_Data
);

   // ALU operation encoding carried in E_control[5:4]
   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_HOLD = 2'b11
   } alu_op_t;

   // Address offset source carried in E_control[3:2]
   typedef enum logic [1:0] {
      OFS_11   = 2'b00,
      OFS_9    = 2'b01,
      OFS_6    = 2'b10,
      OFS_ZERO = 2'b11
   } ofs_sel_t;

   // Decoded view of E_control
   typedef struct packed {
      alu_op_t  alu_op;
      ofs_sel_t ofs_sel;
      logic     base_npc;   // 1: base is npc_in, 0: base is op1
      logic     op2_reg;    // 1: op2 is v2, 0: op2 is sext(IR[4:0])
   } ectl_t;

   // Next values for the pipeline register (everything but aluout,
   // which has its own hold case)
   typedef struct packed {
      logic [DATA_W-1:0] pcout;
      logic [2:0]        dr;
      logic [15:0]       ir;
      logic [2:0]        nzp;
      logic [1:0]        wctl;
      logic              mctl;
      logic [DATA_W-1:0] mdata;
   } exec_res_t;

   localparam logic [3:0] OPC_BR  = 4'b0000;
   localparam logic [3:0] OPC_JMP = 4'b1100;

   ectl_t             ectl;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] v2;
   logic [DATA_W-1:0] op2;
   logic [DATA_W-1:0] imm5;
   logic [DATA_W-1:0] offset;
   logic [DATA_W-1:0] base;
   logic [DATA_W-1:0] alu_nxt;
   exec_res_t         res_nxt;

   assign ectl = ectl_t'(E_control);

   // Source selects go back to the register file in the same cycle
   assign sr1 = IR[8:6];
   assign sr2 = IR[2:0];

   // Forwarding: own result beats the Memory-stage value, which beats the
   // register file. Both bypasses on one operand is legal; ALU wins.
   always_comb begin
      op1 = VSR1;
      if (bypass_alu_1)      op1 = aluout;
      else if (bypass_mem_1) op1 = Mem_bypass_val;
      v2 = VSR2;
      if (bypass_alu_2)      v2 = aluout;
      else if (bypass_mem_2) v2 = Mem_bypass_val;
   end

   // Second ALU operand: forwarded register value or 5-bit immediate
   always_comb begin
      imm5 = {{(DATA_W-5){IR[4]}}, IR[4:0]};
      op2  = ectl.op2_reg ? v2 : imm5;
   end

   // ALU; the reserved encoding keeps the previous result
   always_comb begin
      alu_nxt = aluout;
      unique case (ectl.alu_op)
         ALU_ADD:  alu_nxt = op1 + op2;
         ALU_AND:  alu_nxt = op1 & op2;
         ALU_NOT:  alu_nxt = ~op1;
         ALU_HOLD: alu_nxt = aluout;
         default:  alu_nxt = aluout;
      endcase
   end

   // Address generation: sign-extended IR offset plus PC or register base
   always_comb begin
      offset = '0;
      unique case (ectl.ofs_sel)
         OFS_11:   offset = {{(DATA_W-11){IR[10]}}, IR[10:0]};
         OFS_9:    offset = {{(DATA_W-9){IR[8]}},   IR[8:0]};
         OFS_6:    offset = {{(DATA_W-6){IR[5]}},   IR[5:0]};
         OFS_ZERO: offset = '0;
         default:  offset = '0;
      endcase
      base = ectl.base_npc ? npc_in : op1;
   end

   // Assemble the remaining pipeline-register inputs, including the branch
   // condition mask (BR takes its nzp field, JMP is unconditional)
   always_comb begin
      res_nxt       = '0;
      res_nxt.pcout = base + offset;
      res_nxt.dr    = IR[11:9];
      res_nxt.ir    = IR;
      res_nxt.wctl  = W_control_in;
      res_nxt.mctl  = Mem_control_in;
      res_nxt.mdata = v2;
      if (IR[15:12] == OPC_BR)       res_nxt.nzp = IR[11:9];
      else if (IR[15:12] == OPC_JMP) res_nxt.nzp = 3'b111;
      else                           res_nxt.nzp = 3'b000;
   end

   // Pipeline register: loads only when the stage is enabled
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         aluout          <= '0;
         pcout           <= '0;
         dr              <= '0;
         IR_Exec         <= '0;
         NZP             <= RESET_NZP;
         W_control_out   <= '0;
         Mem_control_out <= 1'b0;
         M_Data          <= '0;
      end else if (enable_execute) begin
         aluout          <= alu_nxt;
         pcout           <= res_nxt.pcout;
         dr              <= res_nxt.dr;
         IR_Exec         <= res_nxt.ir;
         NZP             <= res_nxt.nzp;
         W_control_out   <= res_nxt.wctl;
         Mem_control_out <= res_nxt.mctl;
         M_Data          <= res_nxt.mdata;
      end
   end

`ifdef LC3_EXEC_VALID_EN
   // Flags the cycle after an enabled edge as carrying fresh results
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) exec_valid <= 1'b0;
      else        exec_valid <= enable_execute;
   end
`endif

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Directed-vector bench for lc3_execute_stage.
module tb_lc3_execute_stage;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable_execute = 1'b0;
   logic [15:0] IR = '0, npc_in = '0, Mem_bypass_val = '0, VSR1 = '0, VSR2 = '0;
   logic [5:0]  E_control = '0;
   logic [1:0]  W_control_in = '0;
   logic        Mem_control_in = 1'b0;
   logic        bypass_alu_1 = 1'b0, bypass_alu_2 = 1'b0, bypass_mem_1 = 1'b0, bypass_mem_2 = 1'b0;
   logic [15:0] aluout, pcout, IR_Exec, M_Data;
   logic [2:0]  dr, sr1, sr2, NZP;
   logic [1:0]  W_control_out;
   logic        Mem_control_out;
`ifdef LC3_EXEC_VALID_EN
   logic        exec_valid;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   lc3_execute_stage #(.DATA_W(16), .RESET_NZP(3'b000)) dut (
      .clock(clock), .reset(reset), .enable_execute(enable_execute),
      .IR(IR), .npc_in(npc_in), .E_control(E_control),
      .W_control_in(W_control_in), .Mem_control_in(Mem_control_in),
      .Mem_bypass_val(Mem_bypass_val), .VSR1(VSR1), .VSR2(VSR2),
      .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
      .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
`ifdef LC3_EXEC_VALID_EN
      .exec_valid(exec_valid),
`endif
      .aluout(aluout), .pcout(pcout), .dr(dr), .sr1(sr1), .sr2(sr2),
      .IR_Exec(IR_Exec), .NZP(NZP), .W_control_out(W_control_out),
      .Mem_control_out(Mem_control_out), .M_Data(M_Data)
   );

   always #5 clock = ~clock;

   // Advance one edge and sample just after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_bypass();
      bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
   endtask

   task automatic test_reset();
      IR = 16'($urandom); npc_in = 16'($urandom); VSR1 = 16'($urandom); VSR2 = 16'($urandom);
      Mem_bypass_val = 16'($urandom); E_control = 6'($urandom); W_control_in = 2'b11;
      Mem_control_in = 1; enable_execute = 1;
      step();
      #2 reset = 0;   // between edges: must clear without a clock
      #1;
      n_checks++; if (aluout !== 16'h0) begin n_fail++; $display("FAIL reset aluout: got %h exp %h", aluout, 16'h0); end
      n_checks++; if (pcout !== 16'h0) begin n_fail++; $display("FAIL reset pcout: got %h exp %h", pcout, 16'h0); end
      n_checks++; if (dr !== 3'h0) begin n_fail++; $display("FAIL reset dr: got %h exp %h", dr, 3'h0); end
      n_checks++; if (IR_Exec !== 16'h0) begin n_fail++; $display("FAIL reset IR_Exec: got %h exp %h", IR_Exec, 16'h0); end
      n_checks++; if (NZP !== 3'b000) begin n_fail++; $display("FAIL reset NZP: got %b exp %b", NZP, 3'b000); end
      n_checks++; if (W_control_out !== 2'b00) begin n_fail++; $display("FAIL reset W_control_out: got %b exp %b", W_control_out, 2'b00); end
      n_checks++; if (Mem_control_out !== 1'b0) begin n_fail++; $display("FAIL reset Mem_control_out: got %b exp %b", Mem_control_out, 1'b0); end
      n_checks++; if (M_Data !== 16'h0) begin n_fail++; $display("FAIL reset M_Data: got %h exp %h", M_Data, 16'h0); end
`ifdef LC3_EXEC_VALID_EN
      n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL reset exec_valid: got %b exp %b", exec_valid, 1'b0); end
`endif
      step();
      enable_execute = 0;
      step();
      reset = 1;
      step(); step();
      n_checks++; if ({aluout, pcout, M_Data, IR_Exec} !== 64'h0) begin n_fail++; $display("FAIL reset_hold regs: got %h exp %h", {aluout, pcout, M_Data, IR_Exec}, 64'h0); end
      n_checks++; if (NZP !== 3'b000) begin n_fail++; $display("FAIL reset_hold NZP: got %b exp %b", NZP, 3'b000); end
      IR = 16'h01C5; #1;
      n_checks++; if (sr1 !== 3'd7 || sr2 !== 3'd5) begin n_fail++; $display("FAIL sr_comb: got %0d/%0d exp 7/5", sr1, sr2); end
   endtask

   // ADD immediate then a back-to-back dependent ADD through the ALU bypass
   task automatic test_back_to_back();
      clear_bypass();
      IR = 16'h1261; E_control = 6'b000000; VSR1 = 16'h0005; VSR2 = 16'h0000;
      npc_in = 16'h3000; W_control_in = 2'b01; Mem_control_in = 0; enable_execute = 1;
      step();
      n_checks++; if (aluout !== 16'h0006) begin n_fail++; $display("FAIL add_imm aluout: got %h exp %h", aluout, 16'h0006); end
      n_checks++; if (dr !== 3'd1) begin n_fail++; $display("FAIL add_imm dr: got %0d exp %0d", dr, 1); end
      n_checks++; if (pcout !== 16'h0266) begin n_fail++; $display("FAIL add_imm pcout: got %h exp %h", pcout, 16'h0266); end
      n_checks++; if (NZP !== 3'b000) begin n_fail++; $display("FAIL add_imm NZP: got %b exp %b", NZP, 3'b000); end
      n_checks++; if (W_control_out !== 2'b01) begin n_fail++; $display("FAIL add_imm W_control_out: got %b exp %b", W_control_out, 2'b01); end
`ifdef LC3_EXEC_VALID_EN
      n_checks++; if (exec_valid !== 1'b1) begin n_fail++; $display("FAIL add_imm exec_valid: got %b exp %b", exec_valid, 1'b1); end
`endif
      bypass_alu_1 = 1; bypass_mem_1 = 1; Mem_bypass_val = 16'h00FF;
      step();
      n_checks++; if (aluout !== 16'h0007) begin n_fail++; $display("FAIL bypass_alu aluout: got %h exp %h", aluout, 16'h0007); end
      // mem bypass on operand 2, register ADD: 0x0023 + 0x0100
      clear_bypass(); bypass_mem_2 = 1;
      IR = 16'h1042; E_control = 6'b000001; VSR1 = 16'h0023; VSR2 = 16'hDEAD; Mem_bypass_val = 16'h0100;
      step();
      n_checks++; if (aluout !== 16'h0123) begin n_fail++; $display("FAIL bypass_mem aluout: got %h exp %h", aluout, 16'h0123); end
      n_checks++; if (M_Data !== 16'h0100) begin n_fail++; $display("FAIL bypass_mem M_Data: got %h exp %h", M_Data, 16'h0100); end
      clear_bypass();
   endtask

   task automatic test_branch();
      IR = 16'h0FFE; npc_in = 16'h3001; E_control = 6'b000110; VSR1 = 16'h0010; VSR2 = 16'h1234;
      W_control_in = 2'b10; Mem_control_in = 1; enable_execute = 1;
      step();
      n_checks++; if (pcout !== 16'h2FFF) begin n_fail++; $display("FAIL branch pcout: got %h exp %h", pcout, 16'h2FFF); end
      n_checks++; if (NZP !== 3'b111) begin n_fail++; $display("FAIL branch NZP: got %b exp %b", NZP, 3'b111); end
      n_checks++; if (aluout !== 16'h000E) begin n_fail++; $display("FAIL branch aluout: got %h exp %h", aluout, 16'h000E); end
      n_checks++; if (IR_Exec !== 16'h0FFE) begin n_fail++; $display("FAIL branch IR_Exec: got %h exp %h", IR_Exec, 16'h0FFE); end
      n_checks++; if (M_Data !== 16'h1234) begin n_fail++; $display("FAIL branch M_Data: got %h exp %h", M_Data, 16'h1234); end
      n_checks++; if (Mem_control_out !== 1'b1) begin n_fail++; $display("FAIL branch Mem_control_out: got %b exp %b", Mem_control_out, 1'b1); end
   endtask

   // Registered state from test_branch must survive three disabled edges
   task automatic test_hold();
      enable_execute = 0;
      for (int i = 0; i < 3; i++) begin
         IR = 16'h5000 + 16'(i * 16'h0111); npc_in = 16'(16'h1000 * i); VSR1 = 16'(i + 16'h0A0);
         VSR2 = ~VSR1; E_control = 6'(i * 7); W_control_in = 2'(i); Mem_control_in = i[0];
         step();
         n_checks++; if ({aluout, pcout, M_Data, IR_Exec} !== {16'h000E, 16'h2FFF, 16'h1234, 16'h0FFE}) begin
            n_fail++; $display("FAIL hold%0d words: got %h exp %h", i, {aluout, pcout, M_Data, IR_Exec}, {16'h000E, 16'h2FFF, 16'h1234, 16'h0FFE}); end
         n_checks++; if ({dr, NZP, W_control_out, Mem_control_out} !== {3'd7, 3'b111, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL hold%0d fields: got %h exp %h", i, {dr, NZP, W_control_out, Mem_control_out}, {3'd7, 3'b111, 2'b10, 1'b1}); end
         n_checks++; if (sr1 !== IR[8:6] || sr2 !== IR[2:0]) begin n_fail++; $display("FAIL hold%0d sr: got %0d/%0d", i, sr1, sr2); end
`ifdef LC3_EXEC_VALID_EN
         n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL hold%0d exec_valid: got %b exp %b", i, exec_valid, 1'b0); end
`endif
      end
   endtask

   task automatic test_alu_ops();
      enable_execute = 1; W_control_in = 2'b00; Mem_control_in = 0;
      IR = 16'h903F; E_control = 6'b100000; VSR1 = 16'h0000;
      step();
      n_checks++; if (aluout !== 16'hFFFF) begin n_fail++; $display("FAIL not_wrap aluout: got %h exp %h", aluout, 16'hFFFF); end
      IR = 16'h1042; E_control = 6'b000001; VSR1 = 16'hFFFF; VSR2 = 16'h0001;
      step();
      n_checks++; if (aluout !== 16'h0000) begin n_fail++; $display("FAIL add_wrap aluout: got %h exp %h", aluout, 16'h0000); end
      IR = 16'h5042; E_control = 6'b010001; VSR1 = 16'hF0F0; VSR2 = 16'h3C3C;
      step();
      n_checks++; if (aluout !== 16'h3030) begin n_fail++; $display("FAIL and aluout: got %h exp %h", aluout, 16'h3030); end
      // reserved ALU code: aluout holds, other fields still load
      IR = 16'h1A42; E_control = 6'b110001; VSR1 = 16'h1111; VSR2 = 16'h2222;
      step();
      n_checks++; if (aluout !== 16'h3030) begin n_fail++; $display("FAIL alu11_hold aluout: got %h exp %h", aluout, 16'h3030); end
      n_checks++; if (dr !== 3'd5) begin n_fail++; $display("FAIL alu11_hold dr: got %0d exp %0d", dr, 5); end
      n_checks++; if (M_Data !== 16'h2222) begin n_fail++; $display("FAIL alu11_hold M_Data: got %h exp %h", M_Data, 16'h2222); end
   endtask

   task automatic test_addr_modes();
      enable_execute = 1;
      // JMP R7: zero offset, register base
      IR = 16'hC1C0; E_control = 6'b001100; VSR1 = 16'h4000;
      step();
      n_checks++; if (pcout !== 16'h4000) begin n_fail++; $display("FAIL jmp pcout: got %h exp %h", pcout, 16'h4000); end
      n_checks++; if (NZP !== 3'b111) begin n_fail++; $display("FAIL jmp NZP: got %b exp %b", NZP, 3'b111); end
      // LDR R5,R0,#-1: 6-bit offset on register base
      IR = 16'h6A3F; E_control = 6'b001000; VSR1 = 16'h5000;
      step();
      n_checks++; if (pcout !== 16'h4FFF) begin n_fail++; $display("FAIL ldr pcout: got %h exp %h", pcout, 16'h4FFF); end
      n_checks++; if (NZP !== 3'b000) begin n_fail++; $display("FAIL ldr NZP: got %b exp %b", NZP, 3'b000); end
      n_checks++; if (aluout !== 16'h4FFF) begin n_fail++; $display("FAIL ldr aluout: got %h exp %h", aluout, 16'h4FFF); end
      // JSR with negative 11-bit offset from npc
      IR = 16'h4C00; E_control = 6'b000010; npc_in = 16'h3000; VSR1 = 16'h0001;
      step();
      n_checks++; if (pcout !== 16'h2C00) begin n_fail++; $display("FAIL jsr pcout: got %h exp %h", pcout, 16'h2C00); end
      n_checks++; if (aluout !== 16'h0001) begin n_fail++; $display("FAIL jsr aluout: got %h exp %h", aluout, 16'h0001); end
   endtask

   // Reset arriving between edges wipes a loaded result
   task automatic test_midop_reset();
      IR = 16'h0E05; E_control = 6'b000110; npc_in = 16'h1000; enable_execute = 1;
      step();
      n_checks++; if (NZP !== 3'b111) begin n_fail++; $display("FAIL midop_pre NZP: got %b exp %b", NZP, 3'b111); end
      #2 reset = 0; #1;
      n_checks++; if (pcout !== 16'h0 || NZP !== 3'b000) begin n_fail++; $display("FAIL midop_reset: got %h/%b exp 0000/000", pcout, NZP); end
      step();
      reset = 1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_branch();
      test_hold();
      test_alu_ops();
      test_addr_modes();
      test_midop_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
